// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: general-purpose CPU register file, two combinational read
// ports (rs/rt) and one clocked write port, with r0 hardwired to zero and a
// saturating count of committed writes.
//
// Build option: define REGFILE_BYPASS_EN for write-first forwarding. The
// value being written is then returned on a read port that addresses the
// same register in the same cycle. When it is undefined the register file
// is read-first and a read returns the stored contents.
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [15:0]           wr_count
);

    // Every address must select a real register, so no read can produce X.
    generate
        if (NUM_REGS != (2 ** ADDR_WIDTH)) begin : g_bad_size
            $error("reg_file_2r1w: NUM_REGS must equal 2**ADDR_WIDTH");
        end
    endgenerate

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [NUM_REGS-1:0]        wr_stb;
    logic [DATA_WIDTH-1:0]      regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]      stored1;
    logic [DATA_WIDTH-1:0]      stored2;
    logic                       wr_commit;

    // One-hot write strobes. Address 0 never gets a strobe, so a write to
    // r0 is dropped here and the counter never sees it.
    always_comb begin
        wr_stb = '0;
        if (we && (waddr != '0)) begin
            wr_stb[waddr] = 1'b1;
        end
    end

    assign wr_commit = |wr_stb;

    // Register storage. Reset takes priority over a write in the same cycle.
    // Entry 0 is held at zero so that a read of r0 needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            regs[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_stb[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Committed-write counter. It saturates and does not wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_commit && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Read the stored contents for both ports with no added latency.
    always_comb begin
        stored1 = regs[raddr1];
        stored2 = regs[raddr2];
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Write-first. A read of the register being written returns the incoming
    // data. This is suppressed while reset is asserted because that write
    // never commits.
    always_comb begin
        fwd1   = we && !rst && (waddr != '0) && (waddr == raddr1);
        fwd2   = we && !rst && (waddr != '0) && (waddr == raddr2);
        rdata1 = fwd1 ? wdata : stored1;
        rdata2 = fwd2 ? wdata : stored2;
    end
`else
    // Read-first. Same-cycle reads return the old contents.
    always_comb begin
        rdata1 = stored1;
        rdata2 = stored2;
    end
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w. Inputs change 1ns after a
// rising edge. Outputs are sampled on the falling edge.
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [15:0] wr_count;

    int compared;
    int mismatched;

    reg_file_2r1w #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NUM_REGS  (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge. New inputs may be driven on return.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one write. It commits on the next rising edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        raddr1 = 5'd5;
        raddr2 = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_r5: got %h want %h", rdata1, 32'h0);
        end
        compared++;
        if (wr_count !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_wr_count: got %0d want 0", wr_count);
        end
        compared++;
        if (rdata2 !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_r0: got %h want %h", rdata2, 32'h0);
        end
        tick();
    endtask

    // A write in the first cycle after reset deasserts is accepted and counted.
    task automatic test_reset_release();
        rst   = 1'b1;
        we    = 1'b1;
        waddr = 5'd6;
        wdata = 32'h11111111;
        tick();
        rst   = 1'b0;
        wdata = 32'h22222222;
        tick();
        we     = 1'b0;
        raddr1 = 5'd6;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'h22222222) begin
            mismatched++;
            $display("FAIL reset_release_r6: got %h want %h", rdata1, 32'h22222222);
        end
        compared++;
        if (wr_count !== 16'd1) begin
            mismatched++;
            $display("FAIL reset_release_count: got %0d want 1", wr_count);
        end
        // Return to a clean reset state for the tests that follow.
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_write(5'd9, 32'h12345678);
        do_write(5'd31, 32'hCAFEF00D);
        raddr1 = 5'd9;
        raddr2 = 5'd31;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'h12345678) begin
            mismatched++;
            $display("FAIL basic_r9: got %h want %h", rdata1, 32'h12345678);
        end
        compared++;
        if (rdata2 !== 32'hCAFEF00D) begin
            mismatched++;
            $display("FAIL basic_r31: got %h want %h", rdata2, 32'hCAFEF00D);
        end
        compared++;
        if (wr_count !== 16'd2) begin
            mismatched++;
            $display("FAIL basic_count: got %0d want 2", wr_count);
        end
        tick();
    endtask

    task automatic test_r0();
        do_write(5'd0, 32'hFFFFFFFF);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'h0) begin
            mismatched++;
            $display("FAIL r0_read1: got %h want 0", rdata1);
        end
        compared++;
        if (rdata2 !== 32'h0) begin
            mismatched++;
            $display("FAIL r0_read2: got %h want 0", rdata2);
        end
        compared++;
        if (wr_count !== 16'd2) begin
            mismatched++;
            $display("FAIL r0_count: got %0d want 2", wr_count);
        end
        tick();
    endtask

    task automatic test_hazard();
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h2;
`else
        exp_same = 32'h1;
`endif
        do_write(5'd4, 32'h1);
        we     = 1'b1;
        waddr  = 5'd4;
        wdata  = 32'h2;
        raddr1 = 5'd4;
        raddr2 = 5'd9;
        @(negedge clk);
        compared++;
        if (rdata1 !== exp_same) begin
            mismatched++;
            $display("FAIL hazard_same_cycle: got %h want %h", rdata1, exp_same);
        end
        compared++;
        if (rdata2 !== 32'h12345678) begin
            mismatched++;
            $display("FAIL hazard_other_port: got %h want %h", rdata2, 32'h12345678);
        end
        tick();
        we = 1'b0;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'h2) begin
            mismatched++;
            $display("FAIL hazard_next_cycle: got %h want %h", rdata1, 32'h2);
        end
        compared++;
        if (wr_count !== 16'd4) begin
            mismatched++;
            $display("FAIL hazard_count: got %0d want 4", wr_count);
        end
        tick();
    endtask

    // While reset is held no forwarding occurs, so stored values are read.
    task automatic test_hazard_in_reset();
        rst    = 1'b1;
        we     = 1'b1;
        waddr  = 5'd4;
        wdata  = 32'h3;
        raddr1 = 5'd4;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'h2) begin
            mismatched++;
            $display("FAIL hazard_rst_nofwd: got %h want %h", rdata1, 32'h2);
        end
        tick();
        rst = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'h0) begin
            mismatched++;
            $display("FAIL hazard_rst_cleared: got %h want 0", rdata1);
        end
        tick();
    endtask

    task automatic test_dual_port();
        do_write(5'd7, 32'hA5A5A5A5);
        raddr1 = 5'd7;
        raddr2 = 5'd7;
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'hA5A5A5A5) begin
            mismatched++;
            $display("FAIL dual_port1: got %h want %h", rdata1, 32'hA5A5A5A5);
        end
        compared++;
        if (rdata2 !== 32'hA5A5A5A5) begin
            mismatched++;
            $display("FAIL dual_port2: got %h want %h", rdata2, 32'hA5A5A5A5);
        end
        tick();
        we    = 1'b0;
        waddr = 5'd7;
        wdata = 32'h0;
        tick();
        @(negedge clk);
        compared++;
        if (rdata1 !== 32'hA5A5A5A5) begin
            mismatched++;
            $display("FAIL we_gating_r7: got %h want %h", rdata1, 32'hA5A5A5A5);
        end
        compared++;
        if (wr_count !== 16'd1) begin
            mismatched++;
            $display("FAIL we_gating_count: got %0d want 1", wr_count);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), {27'h0, 5'(i)});
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            exp = 32'(i);
            @(negedge clk);
            compared++;
            if (rdata1 !== exp) begin
                mismatched++;
                $display("FAIL sweep_p1_r%0d: got %h want %h", i, rdata1, exp);
            end
            compared++;
            if (rdata2 !== 32'(31 - i)) begin
                mismatched++;
                $display("FAIL sweep_p2_r%0d: got %h want %h", 31 - i, rdata2, 32'(31 - i));
            end
            tick();
        end
        compared++;
        if (wr_count !== 16'd31) begin
            mismatched++;
            $display("FAIL sweep_count: got %0d want 31", wr_count);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst    = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        test_reset();
        test_reset_release();
        test_basic();
        test_r0();
        test_hazard();
        test_hazard_in_reset();
        test_dual_port();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
